// File: rtl/cpu_fetch.sv
// ---------------------------------------------------------------------------
// cpu_fetch
//
// Instruction fetch unit for the 6502 core. After reset it reads the two-byte
// reset vector, then streams instructions out of byte-wide synchronous memory.
// Each opcode is shown to the instruction decoder in the cycle its data
// arrives. The decoder's length answer decides how many operand bytes (0..2)
// are gathered. The complete instruction is then held on a valid/ready
// handshake toward the execute stage. Jumps, branches and returns steer the
// unit through pc_load.
//
// Ports:
//   clk           in   1  system clock
//   rst           in   1  synchronous, active-high reset
//   mem_addr      out 16  memory read address
//   mem_re        out  1  read strobe, data returns on mem_rdata next cycle
//   mem_rdata     in   8  read data
//   dec_opcode    out  8  opcode presented to the decoder
//   dec_length    in   2  instruction length from the decoder (0 means 1)
//   pc_load       in   1  redirect request
//   pc_load_addr  in  16  redirect target
//   instr_valid   out  1  a complete instruction is presented
//   instr_ready   in   1  execute stage accepts the instruction
//   instr_opcode  out  8  opcode of the presented instruction
//   instr_operand out 16  operand bytes {hi, lo}, unused bytes are 0
//   instr_pc      out 16  address of the opcode
//   next_pc       out 16  instr_pc + length, wrapping at 64K
//   busy          out  1  high whenever no instruction is presented
// ---------------------------------------------------------------------------
module cpu_fetch #(
   parameter logic [15:0] VECTOR_ADDR = 16'hFFFC
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] mem_addr,
   output logic        mem_re,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  dec_opcode,
   input  logic [1:0]  dec_length,
   input  logic        pc_load,
   input  logic [15:0] pc_load_addr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [7:0]  instr_opcode,
   output logic [15:0] instr_operand,
   output logic [15:0] instr_pc,
   output logic [15:0] next_pc,
   output logic        busy
);

   localparam logic [2:0] VEC_LO   = 3'd0;
   localparam logic [2:0] VEC_HI   = 3'd1;
   localparam logic [2:0] VEC_CAP  = 3'd2;
   localparam logic [2:0] FETCH_OP = 3'd3;
   localparam logic [2:0] CAPT_OP  = 3'd4;
   localparam logic [2:0] CAPT_LO  = 3'd5;
   localparam logic [2:0] CAPT_HI  = 3'd6;
   localparam logic [2:0] VALID    = 3'd7;

   logic [2:0]  state;
   logic [15:0] pc;
   logic [7:0]  vec_lo;
   logic [7:0]  opcode_r;
   logic [15:0] operand_r;
   logic [1:0]  len_r;

   logic [1:0]  dec_len_eff;
   logic [15:0] pc_plus1;
   logic [15:0] pc_plus2;
   logic        redirect_ok;
   logic        redirect;

   // Unimplemented opcodes come back from the decoder as length 0; they are
   // stepped over as single-byte instructions so the stream never stalls.
   assign dec_len_eff = (dec_length == 2'd0) ? 2'd1 : dec_length;

   // Operand addresses and the fall-through address all wrap at 64K because
   // the adders are exactly 16 bits wide.
   assign pc_plus1 = pc + 16'd1;
   assign pc_plus2 = pc + 16'd2;
   assign next_pc  = pc + {14'd0, len_r};

   // Redirects are only honoured once the vector has been loaded; during the
   // vector fetch there is no meaningful pc to replace.
   assign redirect_ok = (state != VEC_LO) && (state != VEC_HI) && (state != VEC_CAP);
   assign redirect    = pc_load && redirect_ok;

   // The decoder sees the opcode straight off the memory bus while it is being
   // captured, so the length answer can steer the very same cycle.
   assign dec_opcode = (state == CAPT_OP) ? mem_rdata : opcode_r;

   assign instr_valid   = (state == VALID);
   assign busy          = (state != VALID);
   assign instr_opcode  = opcode_r;
   assign instr_operand = operand_r;
   assign instr_pc      = pc;

   // Memory request decode. Reads are only issued when their data will be
   // used next cycle. A redirect discards whatever would come back, so the
   // strobe is dropped to keep the bus quiet until the new target is fetched.
   // While rst is high the bus is forced idle regardless of state.
   always_comb begin
      mem_re   = 1'b0;
      mem_addr = 16'h0000;
      case (state)
         VEC_LO: begin
            mem_re   = 1'b1;
            mem_addr = VECTOR_ADDR;
         end
         VEC_HI: begin
            mem_re   = 1'b1;
            mem_addr = VECTOR_ADDR + 16'd1;
         end
         FETCH_OP: begin
            mem_re   = 1'b1;
            mem_addr = pc;
         end
         CAPT_OP: begin
            if (dec_len_eff != 2'd1) begin
               mem_re   = 1'b1;
               mem_addr = pc_plus1;
            end
         end
         CAPT_LO: begin
            if (len_r == 2'd3) begin
               mem_re   = 1'b1;
               mem_addr = pc_plus2;
            end
         end
         VALID: begin
            if (instr_ready) begin
               mem_re   = 1'b1;
               mem_addr = next_pc;
            end
         end
         default: begin
            mem_re   = 1'b0;
            mem_addr = 16'h0000;
         end
      endcase
      if (redirect) begin
         mem_re = 1'b0;
      end
      if (rst) begin
         mem_re   = 1'b0;
         mem_addr = 16'h0000;
      end
   end

   // Fetch sequencer. A redirect overrides everything else; when it lands on a
   // handshake cycle the presented instruction still counts as consumed, and
   // only the following fetch is steered to the new target. On a normal
   // handshake the read of next_pc has already been issued this cycle, so the
   // sequencer skips FETCH_OP and goes straight to capturing the opcode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= VEC_LO;
         pc        <= 16'h0000;
         vec_lo    <= 8'h00;
         opcode_r  <= 8'h00;
         operand_r <= 16'h0000;
         len_r     <= 2'd0;
      end else if (redirect) begin
         pc    <= pc_load_addr;
         state <= FETCH_OP;
      end else begin
         case (state)
            VEC_LO: begin
               state <= VEC_HI;
            end
            VEC_HI: begin
               vec_lo <= mem_rdata;
               state  <= VEC_CAP;
            end
            VEC_CAP: begin
               pc    <= {mem_rdata, vec_lo};
               state <= FETCH_OP;
            end
            FETCH_OP: begin
               state <= CAPT_OP;
            end
            CAPT_OP: begin
               opcode_r  <= mem_rdata;
               len_r     <= dec_len_eff;
               operand_r <= 16'h0000;
               if (dec_len_eff == 2'd1) begin
                  state <= VALID;
               end else begin
                  state <= CAPT_LO;
               end
            end
            CAPT_LO: begin
               operand_r[7:0] <= mem_rdata;
               if (len_r == 2'd3) begin
                  state <= CAPT_HI;
               end else begin
                  state <= VALID;
               end
            end
            CAPT_HI: begin
               operand_r[15:8] <= mem_rdata;
               state           <= VALID;
            end
            VALID: begin
               if (instr_ready) begin
                  pc    <= next_pc;
                  state <= CAPT_OP;
               end
            end
            default: begin
               state <= VEC_LO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_fetch.sv
// ---------------------------------------------------------------------------
// tb_cpu_fetch
//
// Self-checking bench for cpu_fetch. A 64K byte memory with one cycle of read
// latency and a small opcode-length table stand in for the rest of the core.
// Delivered instructions are checked by a scoreboard. Expected records are
// queued when a program is set up and popped whenever a handshake is seen.
// Hand-written sequences cover reset, backpressure, redirects, address wrap
// and back-to-back NOPs. A table of single instructions covers the rest.
// ---------------------------------------------------------------------------
module tb_cpu_fetch;

   logic        clk;
   logic        rst;
   logic [15:0] mem_addr;
   logic        mem_re;
   logic [7:0]  mem_rdata = 8'h00;
   logic [7:0]  dec_opcode;
   logic [1:0]  dec_length;
   logic        pc_load;
   logic [15:0] pc_load_addr;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  instr_opcode;
   logic [15:0] instr_operand;
   logic [15:0] instr_pc;
   logic [15:0] next_pc;
   logic        busy;

   typedef struct packed {
      logic [7:0]  op;
      logic [15:0] operand;
      logic [15:0] pc;
      logic [15:0] nxt;
   } exp_t;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
      int          len;
      logic [15:0] exp_operand;
      logic [15:0] exp_next;
   } vec_t;

   logic [7:0] mem [0:65535];
   exp_t       sb_q[$];
   exp_t       mon_e;
   vec_t       vecs[8];
   int         total = 0;
   int         bad = 0;

   cpu_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .mem_addr      (mem_addr),
      .mem_re        (mem_re),
      .mem_rdata     (mem_rdata),
      .dec_opcode    (dec_opcode),
      .dec_length    (dec_length),
      .pc_load       (pc_load),
      .pc_load_addr  (pc_load_addr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_opcode  (instr_opcode),
      .instr_operand (instr_operand),
      .instr_pc      (instr_pc),
      .next_pc       (next_pc),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory: data for a strobed address appears one cycle later.
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   // Decoder stand-in; opcode 02 plays the unimplemented opcode answering 0.
   always_comb begin
      case (dec_opcode)
         8'hA9:   dec_length = 2'd2;
         8'h4C:   dec_length = 2'd3;
         8'h8D:   dec_length = 2'd3;
         8'hAD:   dec_length = 2'd3;
         8'h02:   dec_length = 2'd0;
         default: dec_length = 2'd1;
      endcase
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Scoreboard consumer: every handshake must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL sb_unexpected: got instruction at pc %0h expected none", instr_pc);
         end else begin
            mon_e = sb_q.pop_front();
            checkOutput("sb_instr", 64'({instr_opcode, instr_operand, instr_pc, next_pc}),
                        64'(mon_e));
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redirectTo(input logic [15:0] a);
      pc_load      = 1'b1;
      pc_load_addr = a;
      step();
      pc_load = 1'b0;
      #1;
   endtask

   task automatic waitValid(input int budget, output int n);
      n = 0;
      while (!instr_valid && n < budget) begin
         step();
         n++;
      end
      checkOutput("wait_valid", 64'(instr_valid), 64'd1);
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [15:0] a;
      int          n;
      exp_t        e;
      mem[v.addr] = v.b0;
      a = v.addr + 16'd1;
      mem[a] = v.b1;
      a = v.addr + 16'd2;
      mem[a] = v.b2;
      redirectTo(v.addr);
      checkOutput("vec_fetch_addr", 64'({mem_re, mem_addr}), 64'({1'b1, v.addr}));
      waitValid(8, n);
      checkOutput("vec_latency", 64'(n), 64'(v.len + 1));
      e = '{op: v.b0, operand: v.exp_operand, pc: v.addr, nxt: v.exp_next};
      sb_q.push_back(e);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      #1;
   endtask

   initial begin
      int   n;
      exp_t e;
      logic [15:0] p;

      vecs[0] = '{16'h0200, 8'hA9, 8'h42, 8'h00, 2, 16'h0042, 16'h0202};
      vecs[1] = '{16'h0200, 8'h4C, 8'h34, 8'h12, 3, 16'h1234, 16'h0203};
      vecs[2] = '{16'h1000, 8'hEA, 8'h99, 8'h99, 1, 16'h0000, 16'h1001};
      vecs[3] = '{16'h2000, 8'h02, 8'h55, 8'h66, 1, 16'h0000, 16'h2001};
      vecs[4] = '{16'h3456, 8'h8D, 8'h00, 8'h10, 3, 16'h1000, 16'h3459};
      vecs[5] = '{16'hFFFF, 8'hA9, 8'h77, 8'h00, 2, 16'h0077, 16'h0001};
      vecs[6] = '{16'hFFF0, 8'hAD, 8'hCD, 8'hAB, 3, 16'hABCD, 16'hFFF3};
      vecs[7] = '{16'h4000, 8'h00, 8'h11, 8'h22, 1, 16'h0000, 16'h4001};

      for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
      mem[16'hFFFC] = 8'h00;
      mem[16'hFFFD] = 8'h02;
      mem[16'h0200] = 8'hA9;
      mem[16'h0201] = 8'h42;

      rst          = 1'b1;
      pc_load      = 1'b0;
      pc_load_addr = 16'h0000;
      instr_ready  = 1'b1;

      // Reset state, vector fetch and the first 2-byte instruction.
      repeat (3) step();
      checkOutput("rst_valid", 64'(instr_valid), 64'd0);
      checkOutput("rst_mem", 64'({mem_re, mem_addr}), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd1);
      checkOutput("rst_regs", 64'({instr_opcode, instr_operand, instr_pc, next_pc}), 64'd0);
      checkOutput("rst_dec", 64'(dec_opcode), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("vec_lo_read", 64'({mem_re, mem_addr}), 64'({1'b1, 16'hFFFC}));
      step();
      checkOutput("vec_hi_read", 64'({mem_re, mem_addr}), 64'({1'b1, 16'hFFFD}));
      step();
      checkOutput("vec_cap_idle", 64'(mem_re), 64'd0);
      step();
      checkOutput("first_fetch", 64'({mem_re, mem_addr}), 64'({1'b1, 16'h0200}));
      step();
      checkOutput("capt_dec_opcode", 64'(dec_opcode), 64'hA9);
      checkOutput("capt_lo_read", 64'({mem_re, mem_addr}), 64'({1'b1, 16'h0201}));
      step();
      checkOutput("capt_lo_busy", 64'({instr_valid, busy}), 64'b01);
      step();
      checkOutput("two_byte_valid", 64'({instr_valid, busy}), 64'b10);
      checkOutput("two_byte_fields", 64'({instr_opcode, instr_operand, instr_pc, next_pc}),
                  64'({8'hA9, 16'h0042, 16'h0200, 16'h0202}));
      checkOutput("two_byte_next_read", 64'({mem_re, mem_addr}), 64'({1'b1, 16'h0202}));
      e = '{op: 8'hA9, operand: 16'h0042, pc: 16'h0200, nxt: 16'h0202};
      sb_q.push_back(e);
      step();
      instr_ready = 1'b0;
      #1;

      // Backpressure on a 3-byte instruction.
      mem[16'h0200] = 8'h4C;
      mem[16'h0201] = 8'h34;
      mem[16'h0202] = 8'h12;
      redirectTo(16'h0200);
      waitValid(8, n);
      checkOutput("bp_latency", 64'(n), 64'd4);
      for (int k = 0; k < 5; k++) begin
         checkOutput("bp_valid", 64'(instr_valid), 64'd1);
         checkOutput("bp_mem_re", 64'(mem_re), 64'd0);
         checkOutput("bp_hold", 64'({instr_opcode, instr_operand, instr_pc, next_pc}),
                     64'({8'h4C, 16'h1234, 16'h0200, 16'h0203}));
         step();
      end
      e = '{op: 8'h4C, operand: 16'h1234, pc: 16'h0200, nxt: 16'h0203};
      sb_q.push_back(e);
      instr_ready = 1'b1;
      #1;
      checkOutput("bp_release_read", 64'({mem_re, mem_addr}), 64'({1'b1, 16'h0203}));
      step();
      instr_ready = 1'b0;
      #1;
      checkOutput("bp_drained", 64'(sb_q.size()), 64'd0);

      // Redirect during CAPT_LO of a 3-byte store; only the target is delivered.
      mem[16'h0400] = 8'h8D;
      mem[16'h0401] = 8'h00;
      mem[16'h0402] = 8'h10;
      mem[16'h0300] = 8'hA9;
      mem[16'h0301] = 8'h55;
      redirectTo(16'h0400);
      instr_ready = 1'b1;
      step();
      step();
      pc_load      = 1'b1;
      pc_load_addr = 16'h0300;
      step();
      pc_load = 1'b0;
      #1;
      checkOutput("redir_fetch", 64'({instr_valid, mem_re, mem_addr}), 64'({2'b01, 16'h0300}));
      e = '{op: 8'hA9, operand: 16'h0055, pc: 16'h0300, nxt: 16'h0302};
      sb_q.push_back(e);
      waitValid(8, n);
      checkOutput("redir_latency", 64'(n), 64'd3);
      step();
      instr_ready = 1'b0;
      #1;
      checkOutput("redir_drained", 64'(sb_q.size()), 64'd0);

      // Redirect landing on a handshake: the instruction is still consumed.
      mem[16'h0600] = 8'hA9;
      mem[16'h0601] = 8'h11;
      redirectTo(16'h0600);
      waitValid(8, n);
      e = '{op: 8'hA9, operand: 16'h0011, pc: 16'h0600, nxt: 16'h0602};
      sb_q.push_back(e);
      instr_ready  = 1'b1;
      pc_load      = 1'b1;
      pc_load_addr = 16'h0700;
      step();
      pc_load     = 1'b0;
      instr_ready = 1'b0;
      #1;
      checkOutput("hs_redir_fetch", 64'({instr_valid, mem_re, mem_addr}), 64'({2'b01, 16'h0700}));
      checkOutput("hs_redir_drained", 64'(sb_q.size()), 64'd0);

      // Operand reads wrapping past the top of memory.
      mem[16'hFFFE] = 8'hAD;
      mem[16'hFFFF] = 8'h34;
      mem[16'h0000] = 8'h12;
      redirectTo(16'hFFFE);
      checkOutput("wrap_op_read", 64'({mem_re, mem_addr}), 64'({1'b1, 16'hFFFE}));
      step();
      checkOutput("wrap_lo_read", 64'({mem_re, mem_addr}), 64'({1'b1, 16'hFFFF}));
      step();
      checkOutput("wrap_hi_read", 64'({mem_re, mem_addr}), 64'({1'b1, 16'h0000}));
      step();
      step();
      checkOutput("wrap_fields", 64'({instr_valid, instr_opcode, instr_operand, instr_pc, next_pc}),
                  64'({1'b1, 8'hAD, 16'h1234, 16'hFFFE, 16'h0001}));
      e = '{op: 8'hAD, operand: 16'h1234, pc: 16'hFFFE, nxt: 16'h0001};
      sb_q.push_back(e);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      #1;

      // Back-to-back single-byte instructions, one of them decoding as length 0.
      for (int i = 0; i < 8; i++) begin
         p = 16'h0500 + 16'(i);
         mem[p] = (i == 3) ? 8'h02 : 8'hEA;
      end
      redirectTo(16'h0500);
      for (int i = 0; i < 8; i++) begin
         p = 16'h0500 + 16'(i);
         e = '{op: ((i == 3) ? 8'h02 : 8'hEA), operand: 16'h0000, pc: p, nxt: p + 16'd1};
         sb_q.push_back(e);
      end
      instr_ready = 1'b1;
      waitValid(6, n);
      checkOutput("b2b_first_latency", 64'(n), 64'd2);
      for (int k = 0; k < 8; k++) begin
         checkOutput("b2b_valid_hi", 64'(instr_valid), 64'd1);
         checkOutput("b2b_pc", 64'(instr_pc), 64'(16'h0500 + 16'(k)));
         step();
         checkOutput("b2b_valid_lo", 64'(instr_valid), 64'd0);
         if (k == 7) instr_ready = 1'b0;
         else step();
      end
      #1;
      checkOutput("b2b_drained", 64'(sb_q.size()), 64'd0);

      // Table of single instructions.
      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      // Reset mid-instruction, then a redirect ignored during the vector fetch.
      mem[16'h0800] = 8'hAD;
      mem[16'h0801] = 8'h00;
      mem[16'h0802] = 8'h20;
      redirectTo(16'h0800);
      step();
      step();
      rst = 1'b1;
      step();
      checkOutput("midrst_state", 64'({instr_valid, busy, mem_re, mem_addr}), 64'({3'b010, 16'h0000}));
      checkOutput("midrst_pc", 64'(instr_pc), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("midrst_vec_lo", 64'({mem_re, mem_addr}), 64'({1'b1, 16'hFFFC}));
      step();
      pc_load      = 1'b1;
      pc_load_addr = 16'h7777;
      #1;
      checkOutput("midrst_vec_hi", 64'({mem_re, mem_addr}), 64'({1'b1, 16'hFFFD}));
      step();
      pc_load = 1'b0;
      step();
      checkOutput("pcload_ignored", 64'({mem_re, mem_addr}), 64'({1'b1, 16'h0200}));

      checkOutput("final_drained", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_fetch.md
# cpu_fetch

Instruction fetch unit for the 6502 core: reads the reset vector, then streams instructions from byte-wide synchronous memory. It presents each opcode to the instruction decoder, takes the decoder's length answer back, gathers 0–2 operand bytes, and hands a complete instruction to the execute stage over a valid/ready handshake. Jumps, branches and returns redirect it through `pc_load`.

## Interface
- `VECTOR_ADDR`, 16'hFFFC: address of the reset vector low byte. The high byte is at `VECTOR_ADDR+1`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `mem_addr` out 16: memory read address.
- `mem_re` out 1: read strobe. Data is returned on `mem_rdata` in the next cycle.
- `mem_rdata` in 8: read data, valid the cycle after `mem_re`.
- `dec_opcode` out 8: opcode driven to the decoder.
- `dec_length` in 2: instruction length from the decoder (1–3). A value of 0 is treated as 1.
- `pc_load` in 1: redirect request.
- `pc_load_addr` in 16: redirect target.
- `instr_valid` out 1: a complete instruction is presented.
- `instr_ready` in 1: execute stage accepts the instruction.
- `instr_opcode` out 8: opcode of the presented instruction.
- `instr_operand` out 16: operand bytes as {hi, lo}. Unused bytes read 0.
- `instr_pc` out 16: address of the opcode.
- `next_pc` out 16: `instr_pc + length`, modulo 2^16.
- `busy` out 1: high in every state except VALID.

## Operation
- States: VEC_LO, VEC_HI, VEC_CAP, FETCH_OP, CAPT_OP, CAPT_LO, CAPT_HI, VALID.
- `mem_addr` and `mem_re` are decoded combinationally from state. `mem_re` is forced to 0 while `rst` is high.
- **VEC_LO**: issue read of `VECTOR_ADDR`. Go to VEC_HI.
- **VEC_HI**: latch the low byte, issue read of `VECTOR_ADDR+1`. Go to VEC_CAP.
- **VEC_CAP**: set `pc <= {mem_rdata, lo}`. Go to FETCH_OP.
- **FETCH_OP**: issue read of `pc`. Go to CAPT_OP.
- **CAPT_OP**:
  - `dec_opcode` bypasses to `mem_rdata`; in all other states it is `opcode_r`.
  - Latch `opcode_r` and sample `dec_length` into `len_r`. Clear the operand.
  - Length 1: go to VALID.
  - Otherwise: issue read of `pc+1` and go to CAPT_LO.
- **CAPT_LO**: latch the operand low byte.
  - `len_r`=3: issue read of `pc+2` and go to CAPT_HI.
  - Otherwise: go to VALID.
- **CAPT_HI**: latch the operand high byte. Go to VALID.
- **VALID**: `instr_valid`=1. All `instr_*` outputs and `next_pc` are held stable.
  - Handshake (`instr_valid & instr_ready`): set `pc <= next_pc`, issue read of `next_pc` in the same cycle, and go directly to CAPT_OP (overlapped fetch).
- **pc_load**, in any state from FETCH_OP through VALID:
  - Has highest priority: `pc <= pc_load_addr`, go to FETCH_OP. The in-flight read data is discarded.
  - `instr_valid` is 0 from the next cycle.
  - If `pc_load` coincides with a handshake, the handshake completes (the instruction is consumed) and `pc` takes `pc_load_addr`.
  - `pc_load` is ignored in the VEC_* states.
- All address arithmetic (`pc+1`, `pc+2`, `next_pc`) wraps modulo 2^16.

## Timing
- Reset values:
  - State VEC_LO.
  - `pc`, `opcode_r`, operand and `len_r` all 0.
  - `instr_valid`=0, `mem_re`=0, `mem_addr`=0, `busy`=1.
- First cycle after `rst` falls: `mem_re`=1 with `mem_addr`=`VECTOR_ADDR`.
- The first opcode read (FETCH_OP) is in the 4th cycle after reset release.
- Latency from FETCH_OP to `instr_valid` = length + 1 cycles: 2 for 1-byte, 3 for 2-byte, 4 for 3-byte instructions.
- Sustained rate with `instr_ready` held high: one instruction per length + 1 cycles. NOPs therefore issue every 2 cycles.
- Backpressure: while VALID and `instr_ready`=0, `mem_re`=0 and all outputs are held.
- Reset mid-operation: reset takes effect at the next edge regardless of state, and the vector fetch restarts.
- The decoder path `mem_rdata -> dec_opcode -> dec_length -> next state` is combinational within the CAPT_OP cycle.

## Test plan
- **Reset vector**: mem[$FFFC]=$00, mem[$FFFD]=$02.
  - Required: `mem_re` at $FFFC, then $FFFD, then `mem_addr`=$0200 in cycle 4 after reset release.
- **2-byte instruction**: $0200: A9 42, `instr_ready`=1.
  - Required: `instr_valid` 3 cycles after FETCH_OP, with `instr_opcode`=$A9, `instr_operand`=$0042, `instr_pc`=$0200, `next_pc`=$0202.
- **Backpressure on a 3-byte instruction**: $0200: 4C 34 12, `instr_ready`=0 for 5 cycles.
  - Required: `instr_operand`=$1234 and `next_pc`=$0203, all outputs stable.
  - Required: `mem_re`=0 throughout the stall.
  - Required: on release, a read of $0203 is issued in the handshake cycle.
- **Redirect mid-fetch**: `pc_load`=1 with `pc_load_addr`=$0300 during CAPT_LO of `8D 00 10`.
  - Required: no `instr_valid` for the aborted instruction.
  - Required: the next read is $0300, and the instruction at $0300 is delivered normally.
- **Address wrap**: 3-byte instruction `AD 34 12` at $FFFE.
  - Required: operand reads at $FFFF and $0000, `instr_operand`=$1234, `next_pc`=$0001.
- **Back-to-back 1-byte**: a run of EA bytes, `instr_ready`=1.
  - Required: `instr_valid` pulses every 2 cycles, with `instr_pc` incrementing by 1.
  - Required: a 0 on `dec_length` (unimplemented opcode) is treated as length 1.
